// File: rtl/jtpopeye_sdram_pkg.sv
// Purpose: shared SDRAM command encodings, FSM states and the buffered-write record for the ROM download writer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package jtpopeye_sdram_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP       = 4'b0111;
  localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
  localparam logic [3:0] CMD_WRITE     = 4'b0100;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0] CMD_REFRESH   = 4'b0001;
  localparam logic [3:0] CMD_MODE      = 4'b0000;

  // A10 selects auto-precharge on WRITE and "all banks" on PRECHARGE
  localparam int          A10      = 10;
  localparam logic [12:0] A10_MASK = 13'(1 << A10);

  typedef enum logic [3:0] {
    ST_INIT_WAIT = 4'd0,
    ST_PRE_ALL   = 4'd1,
    ST_REF1      = 4'd2,
    ST_REF2      = 4'd3,
    ST_MODE      = 4'd4,
    ST_IDLE      = 4'd5,
    ST_ACT       = 4'd6,
    ST_WR        = 4'd7,
    ST_REF       = 4'd8
  } state_t;

  typedef struct packed {
    logic [21:0] addr;
    logic [7:0]  data;
    logic [1:0]  mask;
  } prog_wr_t;

  // Column address with auto-precharge requested
  function automatic logic [12:0] wr_addr(input logic [8:0] col);
    return {4'b0000, col} | A10_MASK;
  endfunction

endpackage

// File: rtl/jtpopeye_prog_fifo.sv
// Purpose: synchronous write buffer between the download strobe and the SDRAM sequencer.
// Latency: entry visible on pop_dat the cycle after the push edge.
// Backpressure: none upstream; a push into a full FIFO without a same-cycle pop is dropped and sets sticky overflow.
// Ports: clk_rom/rst_n (sync, active-low); push/push_dat in; pop in, pop_dat = head; full, empty, overflow out.
module jtpopeye_prog_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk_rom,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty,
  output logic         overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign push_ok = push && (!full || pop_ok);
  assign pop_dat = mem[rd_ptr];

  // Storage needs no reset: pointers define which entries are valid
  always_ff @(posedge clk_rom) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk_rom) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
      if (push && !push_ok) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/jtpopeye_prog_sdram.sv
// Purpose: SDRAM writer for ROM download: power-up sequence, then ACTIVE/WRITE-autoprecharge per buffered byte, refresh interleaved.
// Latency: ACTIVE one edge after the write strobe is sampled (idle, empty FIFO), WRITE TRCD edges later.
// Backpressure: none; bytes beyond FIFO_DEPTH are dropped and flagged on sticky overflow.
// Ports: clk_rom, rst_n (sync, active-low); prog_addr/data/mask/we in; sdram_cmd/ba/a/dq/dq_oe/dqm out (registered);
//        init_done, prog_busy, overflow status out.
module jtpopeye_prog_sdram
  import jtpopeye_sdram_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter int          TRCD       = 2,
  parameter int          TWRP       = 4,
  parameter int          TRFC       = 7,
  parameter int          REF_INT    = 780,
  parameter int          INIT_WAIT  = 10000,
  parameter logic [12:0] MODE_REG   = 13'h220
) (
  input  logic        clk_rom,
  input  logic        rst_n,
  input  logic [21:0] prog_addr,
  input  logic [7:0]  prog_data,
  input  logic [1:0]  prog_mask,
  input  logic        prog_we,
  output logic [3:0]  sdram_cmd,
  output logic [1:0]  sdram_ba,
  output logic [12:0] sdram_a,
  output logic [15:0] sdram_dq,
  output logic        sdram_dq_oe,
  output logic [1:0]  sdram_dqm,
  output logic        init_done,
  output logic        prog_busy,
  output logic        overflow
);

  localparam int WAIT_A   = (INIT_WAIT > TRFC) ? INIT_WAIT : TRFC;
  localparam int WAIT_B   = (TWRP > TRCD) ? TWRP : TRCD;
  localparam int WAIT_MAX = (WAIT_A > WAIT_B) ? WAIT_A : WAIT_B;
  localparam int CW       = $clog2(WAIT_MAX + 1);
  localparam int RW       = (REF_INT > 1) ? $clog2(REF_INT) : 1;
  localparam logic [RW-1:0] REF_LAST = RW'(REF_INT - 1);

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [RW-1:0] ref_cnt;
  logic          ref_pend;
  logic          ref_expire;
  prog_wr_t      push_dat;
  prog_wr_t      head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;

  assign push_dat   = {prog_addr, prog_data, prog_mask};
  // The head is consumed on the edge that issues WRITE, while its fields are registered onto the pins
  assign pop        = (state == ST_ACT) && (wait_cnt == '0);
  assign ref_expire = init_done && (ref_cnt == REF_LAST);

  jtpopeye_prog_fifo #(
    .W     ($bits(prog_wr_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_rom  (clk_rom),
    .rst_n    (rst_n),
    .push     (prog_we),
    .push_dat (push_dat),
    .pop      (pop),
    .pop_dat  (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .overflow (overflow)
  );

  // Each state is entered on the edge that issues its command; wait_cnt then
  // counts the NOP cycles before the state's exit decision is taken.
  always_ff @(posedge clk_rom) begin
    if (!rst_n) begin
      state       <= ST_INIT_WAIT;
      wait_cnt    <= CW'(INIT_WAIT);
      ref_cnt     <= '0;
      ref_pend    <= 1'b0;
      init_done   <= 1'b0;
      prog_busy   <= 1'b0;
      sdram_cmd   <= CMD_NOP;
      sdram_ba    <= 2'b00;
      sdram_a     <= '0;
      sdram_dq    <= '0;
      sdram_dq_oe <= 1'b0;
      sdram_dqm   <= 2'b11;
    end else begin
      sdram_cmd   <= CMD_NOP;
      sdram_ba    <= 2'b00;
      sdram_a     <= '0;
      sdram_dq_oe <= 1'b0;
      sdram_dqm   <= 2'b11;
      // Lags the state by one cycle; the strobe term covers a byte still in flight into the FIFO
      prog_busy   <= (state != ST_IDLE) || !fifo_empty || fifo_full || prog_we;

      // Repeated expiries while a request is outstanding fold into it
      if (init_done) begin
        if (ref_cnt == REF_LAST) begin
          ref_cnt  <= '0;
          ref_pend <= 1'b1;
        end else begin
          ref_cnt <= ref_cnt + RW'(1);
        end
      end

      if (wait_cnt != '0) begin
        wait_cnt <= wait_cnt - CW'(1);
      end else begin
        case (state)
          ST_INIT_WAIT: begin
            state     <= ST_PRE_ALL;
            sdram_cmd <= CMD_PRECHARGE;
            sdram_a   <= A10_MASK;
            wait_cnt  <= CW'(2);
          end
          ST_PRE_ALL: begin
            state     <= ST_REF1;
            sdram_cmd <= CMD_REFRESH;
            wait_cnt  <= CW'(TRFC);
          end
          ST_REF1: begin
            state     <= ST_REF2;
            sdram_cmd <= CMD_REFRESH;
            wait_cnt  <= CW'(TRFC);
          end
          ST_REF2: begin
            state     <= ST_MODE;
            sdram_cmd <= CMD_MODE;
            sdram_a   <= MODE_REG;
            wait_cnt  <= CW'(2);
          end
          ST_MODE: begin
            state     <= ST_IDLE;
            init_done <= 1'b1;
          end
          ST_IDLE: begin
            if (ref_pend) begin
              state     <= ST_REF;
              sdram_cmd <= CMD_REFRESH;
              // A fresh expiry on this same edge must survive the clear
              ref_pend  <= ref_expire;
              // The IDLE cycle that follows supplies the last NOP of tRFC
              wait_cnt  <= CW'(TRFC - 1);
            end else if (!fifo_empty) begin
              state     <= ST_ACT;
              sdram_cmd <= CMD_ACTIVE;
              sdram_a   <= head.addr[21:9];
              wait_cnt  <= CW'(TRCD - 1);
            end
          end
          ST_ACT: begin
            state       <= ST_WR;
            sdram_cmd   <= CMD_WRITE;
            sdram_a     <= wr_addr(head.addr[8:0]);
            sdram_dq    <= {head.data, head.data};
            sdram_dq_oe <= 1'b1;
            sdram_dqm   <= head.mask;
            wait_cnt    <= CW'(TWRP - 1);
          end
          ST_WR, ST_REF: begin
            state <= ST_IDLE;
          end
          default: begin
            state    <= ST_INIT_WAIT;
            wait_cnt <= CW'(INIT_WAIT);
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtpopeye_prog_sdram.sv
// Purpose: directed self-checking bench for jtpopeye_prog_sdram (init sequence, writes, refresh collision, overflow, reset).
// Latency: n/a.
// Backpressure: n/a.
module tb_jtpopeye_prog_sdram;

  localparam logic [3:0] C_NOP  = 4'b0111;
  localparam logic [3:0] C_ACT  = 4'b0011;
  localparam logic [3:0] C_WR   = 4'b0100;
  localparam logic [3:0] C_PRE  = 4'b0010;
  localparam logic [3:0] C_REF  = 4'b0001;
  localparam logic [3:0] C_MODE = 4'b0000;
  localparam int R_INT = 100;

  logic        clk_rom = 1'b0;
  logic        rst_n;
  logic [21:0] prog_addr;
  logic [7:0]  prog_data;
  logic [1:0]  prog_mask;
  logic        prog_we;
  logic [3:0]  sdram_cmd;
  logic [1:0]  sdram_ba;
  logic [12:0] sdram_a;
  logic [15:0] sdram_dq;
  logic        sdram_dq_oe;
  logic [1:0]  sdram_dqm;
  logic        init_done;
  logic        prog_busy;
  logic        overflow;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int m_edge   = 0;

  logic [21:0] t_addr [5] = '{22'h000001, 22'h3FFFFF, 22'h000200, 22'h123456, 22'h0ABCDE};
  logic [7:0]  t_data [5] = '{8'h11, 8'hFF, 8'h5A, 8'hA5, 8'h77};
  logic [1:0]  t_mask [5] = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b01};
  logic [12:0] t_row  [5] = '{13'h0000, 13'h1FFF, 13'h0001, 13'h091A, 13'h055E};
  logic [12:0] t_awr  [5] = '{13'h0401, 13'h05FF, 13'h0400, 13'h0456, 13'h04DE};

  jtpopeye_prog_sdram #(
    .FIFO_DEPTH (4),
    .TRCD       (2),
    .TWRP       (4),
    .TRFC       (7),
    .REF_INT    (R_INT),
    .INIT_WAIT  (20),
    .MODE_REG   (13'h220)
  ) dut (
    .clk_rom     (clk_rom),
    .rst_n       (rst_n),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_mask   (prog_mask),
    .prog_we     (prog_we),
    .sdram_cmd   (sdram_cmd),
    .sdram_ba    (sdram_ba),
    .sdram_a     (sdram_a),
    .sdram_dq    (sdram_dq),
    .sdram_dq_oe (sdram_dq_oe),
    .sdram_dqm   (sdram_dqm),
    .init_done   (init_done),
    .prog_busy   (prog_busy),
    .overflow    (overflow)
  );

  always #5 clk_rom = ~clk_rom;
  always @(posedge clk_rom) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int i);
    prog_we   = 1'b1;
    prog_addr = t_addr[i];
    prog_data = t_data[i];
    prog_mask = t_mask[i];
  endtask

  task automatic nops(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk_rom);
      chk(tag, sdram_cmd, C_NOP);
    end
  endtask

  // Called right after rst_n is released at a negedge; pushes npush table entries during the wait
  task automatic init_seq(input int npush);
    for (int i = 0; i < 20; i++) begin
      if (i < npush) drive(i);
      else prog_we = 1'b0;
      @(negedge clk_rom);
      chk("init_wait_nop", sdram_cmd, C_NOP);
    end
    prog_we = 1'b0;
    @(negedge clk_rom);
    chk("pre_cmd", sdram_cmd, C_PRE);
    chk("pre_a10", sdram_a[10], 1);
    nops("pre_nop", 2);
    @(negedge clk_rom);
    chk("ref1_cmd", sdram_cmd, C_REF);
    nops("ref1_nop", 7);
    @(negedge clk_rom);
    chk("ref2_cmd", sdram_cmd, C_REF);
    nops("ref2_nop", 7);
    @(negedge clk_rom);
    chk("mode_cmd", sdram_cmd, C_MODE);
    chk("mode_a", sdram_a, 13'h220);
    chk("mode_init_done", init_done, 0);
    nops("mode_nop", 2);
    chk("pre_idle_init_done", init_done, 0);
    @(negedge clk_rom);
    chk("idle_cmd", sdram_cmd, C_NOP);
    chk("init_done_rise", init_done, 1);
    m_edge = cyc;
  endtask

  task automatic expect_write(input int idx);
    int n;
    n = 0;
    do begin
      @(negedge clk_rom);
      n++;
    end while (sdram_cmd === C_NOP && n < 40);
    chk("act_cmd", sdram_cmd, C_ACT);
    chk("act_row", sdram_a, t_row[idx]);
    chk("act_ba", sdram_ba, 0);
    @(negedge clk_rom);
    chk("trcd_nop", sdram_cmd, C_NOP);
    @(negedge clk_rom);
    chk("wr_cmd", sdram_cmd, C_WR);
    chk("wr_a", sdram_a, t_awr[idx]);
    chk("wr_dq", sdram_dq, {t_data[idx], t_data[idx]});
    chk("wr_dqm", sdram_dqm, t_mask[idx]);
    chk("wr_oe", sdram_dq_oe, 1);
    @(negedge clk_rom);
    chk("post_wr_oe", sdram_dq_oe, 0);
    chk("post_wr_dqm", sdram_dqm, 2'b11);
  endtask

  initial begin
    logic saw;
    rst_n     = 1'b0;
    prog_we   = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    prog_mask = '0;
    repeat (3) @(negedge clk_rom);

    // Reset state
    chk("rst_cmd", sdram_cmd, C_NOP);
    chk("rst_a", sdram_a, 0);
    chk("rst_ba", sdram_ba, 0);
    chk("rst_dq", sdram_dq, 0);
    chk("rst_oe", sdram_dq_oe, 0);
    chk("rst_dqm", sdram_dqm, 2'b11);
    chk("rst_init_done", init_done, 0);
    chk("rst_busy", prog_busy, 0);
    chk("rst_overflow", overflow, 0);

    // Init sequence with 5 pushes into a 4-deep FIFO held during init
    rst_n = 1'b1;
    init_seq(5);
    chk("ovf_sticky", overflow, 1);
    for (int i = 0; i < 4; i++) expect_write(i);
    saw = 1'b0;
    repeat (15) begin
      @(negedge clk_rom);
      if (sdram_cmd !== C_NOP) saw = 1'b1;
    end
    chk("no_fifth_write", saw, 0);
    chk("drained_busy", prog_busy, 0);
    chk("ovf_still_set", overflow, 1);

    // Single write latency from idle
    prog_we   = 1'b1;
    prog_addr = 22'h2A5F3;
    prog_data = 8'hC4;
    prog_mask = 2'b10;
    @(negedge clk_rom);
    prog_we = 1'b0;
    chk("single_busy", prog_busy, 1);
    chk("single_k_nop", sdram_cmd, C_NOP);
    @(negedge clk_rom);
    chk("single_act", sdram_cmd, C_ACT);
    chk("single_row", sdram_a, 13'h0152);
    @(negedge clk_rom);
    chk("single_trcd", sdram_cmd, C_NOP);
    @(negedge clk_rom);
    chk("single_wr", sdram_cmd, C_WR);
    chk("single_a", sdram_a, 13'h05F3);
    chk("single_dq", sdram_dq, 16'hC4C4);
    chk("single_dqm", sdram_dqm, 2'b10);
    chk("single_oe", sdram_dq_oe, 1);
    @(negedge clk_rom);
    chk("single_oe_off", sdram_dq_oe, 0);
    chk("single_dqm_off", sdram_dqm, 2'b11);

    // Refresh collision: push lands on the same edge that raises the refresh request
    while (cyc < m_edge + R_INT - 1) @(negedge clk_rom);
    drive(2);
    @(negedge clk_rom);
    prog_we = 1'b0;
    chk("coll_nop", sdram_cmd, C_NOP);
    @(negedge clk_rom);
    chk("coll_ref_first", sdram_cmd, C_REF);
    nops("coll_trfc_nop", 7);
    @(negedge clk_rom);
    chk("coll_act", sdram_cmd, C_ACT);
    chk("coll_row", sdram_a, t_row[2]);
    @(negedge clk_rom);
    chk("coll_trcd", sdram_cmd, C_NOP);
    @(negedge clk_rom);
    chk("coll_wr", sdram_cmd, C_WR);
    chk("coll_wr_a", sdram_a, t_awr[2]);
    @(negedge clk_rom);
    chk("twrp_nop", sdram_cmd, C_NOP);

    // Reset during the write-recovery wait
    rst_n = 1'b0;
    @(negedge clk_rom);
    chk("mid_rst_cmd", sdram_cmd, C_NOP);
    chk("mid_rst_init_done", init_done, 0);
    chk("mid_rst_busy", prog_busy, 0);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_oe", sdram_dq_oe, 0);
    chk("mid_rst_dqm", sdram_dqm, 2'b11);
    rst_n = 1'b1;
    init_seq(4);

    // Full FIFO: push on the edge that pops the head must be accepted
    @(negedge clk_rom);
    chk("full_act", sdram_cmd, C_ACT);
    chk("full_row", sdram_a, t_row[0]);
    @(negedge clk_rom);
    chk("full_trcd", sdram_cmd, C_NOP);
    drive(4);
    @(negedge clk_rom);
    prog_we = 1'b0;
    chk("full_wr", sdram_cmd, C_WR);
    chk("full_wr_a", sdram_a, t_awr[0]);
    chk("full_pushpop_ovf", overflow, 0);
    @(negedge clk_rom);
    chk("full_oe_off", sdram_dq_oe, 0);
    for (int i = 1; i < 5; i++) expect_write(i);
    chk("full_final_ovf", overflow, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
